// File: rtl/rib_timer_pkg.sv
// Shared register map, CTRL bit positions and the CTRL register layout
// for the rib_timer bus slave.
package rib_timer_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_COUNT    = 2'd1;
  localparam logic [1:0] REG_VALUE    = 2'd2;
  localparam logic [1:0] REG_PRESCALE = 2'd3;

  localparam int unsigned CTRL_EN_BIT      = 32'd0;
  localparam int unsigned CTRL_IE_BIT      = 32'd1;
  localparam int unsigned CTRL_PEND_BIT    = 32'd2;
  localparam int unsigned CTRL_ONESHOT_BIT = 32'd3;

  // Field order puts en at bit 0 so the struct maps directly onto the bus word.
  typedef struct packed {
    logic oneshot;
    logic pend;
    logic ie;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    return {28'd0, c};
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for rib_timer: emits a one-cycle adv pulse every prescale+1
// enabled clocks; the phase counter is held at zero while disabled.
module timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] prescale,
  output logic        adv
);

  logic [31:0] pre_cnt_r;
  logic        hit_s;

  assign hit_s = (pre_cnt_r == prescale);
  assign adv   = en & hit_s;

  // Phase counter: wraps on a match, otherwise counts up (a shrunk prescale
  // simply lets it run round through 2^32).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_r <= 32'd0;
    end else if (!en) begin
      pre_cnt_r <= 32'd0;
    end else if (hit_s) begin
      pre_cnt_r <= 32'd0;
    end else begin
      pre_cnt_r <= pre_cnt_r + 32'd1;
    end
  end

endmodule

// File: rtl/rib_timer.sv
// Memory-mapped timer slave: prescaled 32-bit up-counter with compare,
// periodic/one-shot operation and a level interrupt.
module rib_timer
  import rib_timer_pkg::*;
#(
  parameter logic [31:0] RST_PRESCALE = 32'd0,
  parameter logic [31:0] RST_VALUE    = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        int_sig_o
);

  ctrl_t       ctrl_r, ctrl_nxt_s;
  logic [31:0] count_r, count_nxt_s;
  logic [31:0] value_r, value_nxt_s;
  logic [31:0] prescale_r, prescale_nxt_s;
  logic [31:0] rd_data_s;
  logic [32:0] count_inc_s;
  logic [1:0]  sel_s;
  logic        wr_s, ctrl_wr_s, count_wr_s, value_wr_s, prescale_wr_s;
  logic        pend_clr_s, adv_s, armed_s, expire_s;
  logic        unused_s;

  assign unused_s = ^{addr_i[31:4], addr_i[1:0]};

  assign sel_s         = addr_i[3:2];
  assign wr_s          = req_i & we_i;
  assign ctrl_wr_s     = wr_s & (sel_s == REG_CTRL);
  assign count_wr_s    = wr_s & (sel_s == REG_COUNT);
  assign value_wr_s    = wr_s & (sel_s == REG_VALUE);
  assign prescale_wr_s = wr_s & (sel_s == REG_PRESCALE);
  assign pend_clr_s    = ctrl_wr_s & data_i[CTRL_PEND_BIT];

  timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_r.en),
    .prescale (prescale_r),
    .adv      (adv_s)
  );

  // A zero compare value disarms the timer; the 33-bit compare lets a
  // VALUE written below COUNT fire on the very next advance.
  assign count_inc_s = {1'b0, count_r} + 33'd1;
  assign armed_s     = adv_s & (value_r != 32'd0);
  assign expire_s    = armed_s & (count_inc_s >= {1'b0, value_r});

  // Next-state: bus writes take priority over the counter, except that an
  // expiry always sets PEND even when a W1C lands on the same edge.
  always_comb begin
    ctrl_nxt_s     = ctrl_r;
    count_nxt_s    = count_r;
    value_nxt_s    = value_r;
    prescale_nxt_s = prescale_r;

    if (ctrl_wr_s) begin
      ctrl_nxt_s.en      = data_i[CTRL_EN_BIT];
      ctrl_nxt_s.ie      = data_i[CTRL_IE_BIT];
      ctrl_nxt_s.oneshot = data_i[CTRL_ONESHOT_BIT];
    end else if (expire_s && ctrl_r.oneshot) begin
      ctrl_nxt_s.en = 1'b0;
    end else begin
      ctrl_nxt_s.en = ctrl_r.en;
    end
    ctrl_nxt_s.pend = (ctrl_r.pend & ~pend_clr_s) | expire_s;

    if (count_wr_s) begin
      count_nxt_s = data_i;
    end else if (expire_s) begin
      count_nxt_s = 32'd0;
    end else if (armed_s) begin
      count_nxt_s = count_inc_s[31:0];
    end else begin
      count_nxt_s = count_r;
    end

    if (value_wr_s) begin
      value_nxt_s = data_i;
    end else begin
      value_nxt_s = value_r;
    end

    if (prescale_wr_s) begin
      prescale_nxt_s = data_i;
    end else begin
      prescale_nxt_s = prescale_r;
    end
  end

  // Register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r     <= ctrl_t'(4'd0);
      count_r    <= 32'd0;
      value_r    <= RST_VALUE;
      prescale_r <= RST_PRESCALE;
    end else begin
      ctrl_r     <= ctrl_nxt_s;
      count_r    <= count_nxt_s;
      value_r    <= value_nxt_s;
      prescale_r <= prescale_nxt_s;
    end
  end

  // Read mux.
  always_comb begin
    rd_data_s = 32'd0;
    case (sel_s)
      REG_CTRL:     rd_data_s = ctrl_to_word(ctrl_r);
      REG_COUNT:    rd_data_s = count_r;
      REG_VALUE:    rd_data_s = value_r;
      REG_PRESCALE: rd_data_s = prescale_r;
      default:      rd_data_s = 32'd0;
    endcase
  end

  assign data_o    = (req_i & ~we_i & ~rst) ? rd_data_s : 32'd0;
  assign int_sig_o = ctrl_r.pend & ctrl_r.ie;

endmodule

// File: tb/tb_rib_timer.sv
// Self-checking bench for rib_timer: directed and randomized timer runs
// checked against arithmetic expectations of fire time and count value.
module tb_rib_timer;

  localparam logic [31:0] TB_RST_PRESCALE = 32'd2;
  localparam logic [31:0] TB_RST_VALUE    = 32'd7;
  localparam logic [31:0] A_CTRL     = 32'h0;
  localparam logic [31:0] A_COUNT    = 32'h4;
  localparam logic [31:0] A_VALUE    = 32'h8;
  localparam logic [31:0] A_PRESCALE = 32'hC;

  logic        clk, rst, req, we, irq;
  logic [31:0] addr, wdata, rdata;
  int          errors = 0;
  int          checks = 0;

  rib_timer #(.RST_PRESCALE(TB_RST_PRESCALE), .RST_VALUE(TB_RST_VALUE)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .data_i(wdata), .data_o(rdata), .int_sig_o(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    req = 1'b0; addr = 32'd0;
  endtask

  task automatic clean();
    bus_write(A_CTRL, 32'h4);
    bus_write(A_CTRL, 32'h4);
    bus_write(A_COUNT, 32'd0);
  endtask

  // Enable at edge t; after k edges the count is floor(k/(n+1)) mod v and an
  // expiry has happened at every edge t + m*v*(n+1).
  task automatic run_timer(input int unsigned n, input int unsigned v, input bit oneshot);
    int unsigned p, k, k0;
    logic [31:0] rd;
    p = v * (n + 1);
    clean();
    bus_write(A_PRESCALE, 32'(n));
    bus_write(A_VALUE, 32'(v));
    bus_write(A_CTRL, oneshot ? 32'hB : 32'h3);
    for (k = 1; k <= p; k++) begin
      idle(1);
      check("int_first", {31'd0, irq}, (k >= p) ? 32'd1 : 32'd0);
      bus_read(A_COUNT, rd);
      check("count_first", rd, 32'((k / (n + 1)) % v));
    end
    if (oneshot) begin
      for (k = p + 1; k <= p + 2 * (n + 1) + 2; k++) begin
        idle(1);
        check("int_oneshot_hold", {31'd0, irq}, 32'd1);
        bus_read(A_COUNT, rd);
        check("count_oneshot_frozen", rd, 32'd0);
      end
      bus_read(A_CTRL, rd);
      check("ctrl_after_oneshot", rd, 32'hE);
      bus_write(A_CTRL, 32'hE);
      check("int_oneshot_cleared", {31'd0, irq}, 32'd0);
      for (k = 0; k < p + 2; k++) begin
        idle(1);
        check("int_no_refire", {31'd0, irq}, 32'd0);
      end
      bus_read(A_COUNT, rd);
      check("count_after_oneshot", rd, 32'd0);
    end else begin
      bus_write(A_CTRL, 32'h7);
      k0 = p + 1;
      for (k = k0; k <= 2 * p + 1; k++) begin
        if (k != k0) idle(1);
        check("int_second", {31'd0, irq}, ((k / p) > ((k0 - 1) / p)) ? 32'd1 : 32'd0);
        bus_read(A_COUNT, rd);
        check("count_second", rd, 32'((k / (n + 1)) % v));
      end
    end
  endtask

  task automatic check_reset_regs(input string tag);
    logic [31:0] rd;
    bus_read(A_CTRL, rd);     check({tag, "_ctrl"}, rd, 32'd0);
    bus_read(A_COUNT, rd);    check({tag, "_count"}, rd, 32'd0);
    bus_read(A_VALUE, rd);    check({tag, "_value"}, rd, TB_RST_VALUE);
    bus_read(A_PRESCALE, rd); check({tag, "_prescale"}, rd, TB_RST_PRESCALE);
    check({tag, "_int"}, {31'd0, irq}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, r;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;

    #12;
    check("int_in_reset", {31'd0, irq}, 32'd0);
    bus_read(A_VALUE, rd);
    check("data_in_reset", rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_regs("por");

    // Register readback with the timer stopped.
    clean();
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      bus_write(A_COUNT, r);    bus_read(A_COUNT, rd);    check("rb_count", rd, r);
      r = $urandom;
      bus_write(A_VALUE, r);    bus_read(A_VALUE, rd);    check("rb_value", rd, r);
      r = $urandom;
      bus_write(A_PRESCALE, r); bus_read(A_PRESCALE, rd); check("rb_prescale", rd, r);
    end
    r = $urandom;
    bus_write(A_CTRL, r);
    bus_read(A_CTRL, rd);
    check("rb_ctrl", rd, r & 32'hB);

    run_timer(0, 5, 1'b0);
    run_timer(3, 2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_timer($urandom_range(0, 3), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
    end

    // PEND clear on the expiry edge: set wins.
    clean();
    bus_write(A_PRESCALE, 32'd0);
    bus_write(A_VALUE, 32'd3);
    bus_write(A_CTRL, 32'h3);
    idle(2);
    bus_write(A_CTRL, 32'h7);
    bus_read(A_CTRL, rd);
    check("w1c_collision_ctrl", rd, 32'h7);
    check("w1c_collision_int", {31'd0, irq}, 32'd1);

    // COUNT write on an advance edge: the write wins.
    clean();
    bus_write(A_PRESCALE, 32'd0);
    bus_write(A_VALUE, 32'h100);
    bus_write(A_CTRL, 32'h3);
    idle(2);
    bus_write(A_COUNT, 32'h10);
    bus_read(A_COUNT, rd);
    check("count_write_collision", rd, 32'h10);
    idle(1);
    bus_read(A_COUNT, rd);
    check("count_after_collision", rd, 32'h11);

    // VALUE = 0 never fires; then VALUE below COUNT fires on the next advance.
    clean();
    bus_write(A_PRESCALE, 32'd0);
    bus_write(A_VALUE, 32'd0);
    bus_write(A_CTRL, 32'h3);
    for (int i = 0; i < 10; i++) begin
      idle(10);
      bus_read(A_COUNT, rd);
      check("value0_count", rd, 32'd0);
      check("value0_int", {31'd0, irq}, 32'd0);
    end
    bus_write(A_COUNT, 32'd9);
    bus_read(A_COUNT, rd);
    check("value0_count_written", rd, 32'd9);
    bus_write(A_VALUE, 32'd4);
    check("below_no_fire_yet", {31'd0, irq}, 32'd0);
    idle(1);
    check("below_fires", {31'd0, irq}, 32'd1);
    bus_read(A_COUNT, rd);
    check("below_count_wrapped", rd, 32'd0);

    // Asynchronous reset mid-count with PEND set.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_int", {31'd0, irq}, 32'd0);
    bus_read(A_COUNT, rd);
    check("async_reset_data", rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_regs("midrun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
